// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle ARM-subset datapath.
// The state register has an async active-low reset; all outputs decode from state and instruction fields.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic [1:0] FlagW,
  output logic       PCS,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  state_t     r_state;
  state_t     w_next;

  logic       w_alu_op;
  logic       w_branch;
  logic       w_regw;
  logic       w_memw;
  logic       w_irwrite;
  logic       w_nextpc;
  logic       w_adrsrc;
  logic [1:0] w_resultsrc;
  logic [1:0] w_alusrca;
  logic [1:0] w_alusrcb;
  logic [1:0] w_aluctl;
  logic [1:0] w_flagw;
  logic [3:0] w_cmd;
  logic       w_s;

  assign w_cmd = Funct[4:1];
  assign w_s   = Funct[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Unused encodings 10-15 fall through to the default and recover to FETCH.
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b00:   w_next = Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   w_next = S_MEMADR;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_next = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = S_MEMWB;
      S_EXECR:  w_next = S_ALUWB;
      S_EXECI:  w_next = S_ALUWB;
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_alu_op    = 1'b0;
    w_branch    = 1'b0;
    w_regw      = 1'b0;
    w_memw      = 1'b0;
    w_irwrite   = 1'b0;
    w_nextpc    = 1'b0;
    w_adrsrc    = 1'b0;
    w_resultsrc = 2'b00;
    w_alusrca   = 2'b00;
    w_alusrcb   = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_irwrite   = 1'b1;
        w_nextpc    = 1'b1;
        w_alusrca   = 2'b01;
        w_alusrcb   = 2'b10;
        w_resultsrc = 2'b10;
      end
      S_DECODE: begin
        w_alusrca   = 2'b01;
        w_alusrcb   = 2'b10;
        w_resultsrc = 2'b10;
      end
      S_MEMADR: begin
        w_alusrcb   = 2'b01;
      end
      S_MEMRD: begin
        w_adrsrc    = 1'b1;
      end
      S_MEMWB: begin
        w_resultsrc = 2'b01;
        w_regw      = 1'b1;
      end
      S_MEMWR: begin
        w_adrsrc    = 1'b1;
        w_memw      = 1'b1;
      end
      S_EXECR: begin
        w_alu_op    = 1'b1;
      end
      S_EXECI: begin
        w_alusrcb   = 2'b01;
        w_alu_op    = 1'b1;
      end
      S_ALUWB: begin
        w_regw      = 1'b1;
      end
      S_BRANCH: begin
        w_alusrcb   = 2'b01;
        w_resultsrc = 2'b10;
        w_branch    = 1'b1;
      end
      default: begin
        w_alu_op    = 1'b0;
      end
    endcase
  end

  // Only ADD/SUB produce carry/overflow, so CV flags are written just for those.
  always_comb begin
    w_aluctl = 2'b00;
    w_flagw  = 2'b00;
    if (w_alu_op) begin
      case (w_cmd)
        4'b0100: begin
          w_aluctl = 2'b00;
          w_flagw  = {w_s, w_s};
        end
        4'b0010: begin
          w_aluctl = 2'b01;
          w_flagw  = {w_s, w_s};
        end
        4'b0000: begin
          w_aluctl = 2'b10;
          w_flagw  = {w_s, 1'b0};
        end
        4'b1100: begin
          w_aluctl = 2'b11;
          w_flagw  = {w_s, 1'b0};
        end
        default: begin
          w_aluctl = 2'b00;
          w_flagw  = 2'b00;
        end
      endcase
    end
  end

  assign State      = r_state;
  assign FlagW      = w_flagw;
  assign ALUControl = w_aluctl;
  assign RegW       = w_regw;
  assign MemW       = w_memw;
  assign IRWrite    = w_irwrite;
  assign NextPC     = w_nextpc;
  assign AdrSrc     = w_adrsrc;
  assign ResultSrc  = w_resultsrc;
  assign ALUSrcA    = w_alusrca;
  assign ALUSrcB    = w_alusrcb;
  assign PCS        = (w_regw && (Rd == 4'b1111)) || w_branch;
  assign ImmSrc     = Op;
  assign RegSrc     = {(Op == 2'b01), (Op == 2'b10)};

endmodule
